// File: rtl/std_reg_write_arbiter.sv
// std_reg_write_arbiter
// Arbitrates write access to one shared single-cycle register among
// NUM_REQ clients that each use a go/done handshake.
//
// Flow: IDLE picks a winner and latches its data. ISSUE pulses write_en.
// WAIT holds until the register reports done. DONE returns a one-cycle
// done pulse to the winner.
//
// Build option:
//   STD_REG_ARB_ROUND_ROBIN_EN defined   -> round-robin arbitration.
//   STD_REG_ARB_ROUND_ROBIN_EN undefined -> fixed priority (lowest index wins).
module std_reg_write_arbiter #(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_go,
    input  logic [NUM_REQ*WIDTH-1:0] req_in,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [WIDTH-1:0]         reg_in,
    output logic                     reg_write_en,
    input  logic                     reg_done,
    output logic [IDX_W-1:0]         grant_idx,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q,  last_d;

    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic [WIDTH-1:0] req_data [NUM_REQ];

    assign any_req = |req_go;

    // Unpack the flat client data bus into one word per client
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = req_in[i*WIDTH +: WIDTH];
        end
    end

`ifdef STD_REG_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] cand;
    logic             found;

    // Round-robin: search upward from the client after the last winner,
    // wrapping back to index 0 after NUM_REQ-1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req_go[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`else
    // Fixed priority: the lowest requesting index wins
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_go[i]) begin
                winner = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state, datapath updates and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        grant_d      = grant_q;
        last_d       = last_q;
        req_done     = '0;
        reg_write_en = 1'b0;
        busy         = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    grant_d = winner;
                    data_d  = req_data[winner];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                reg_write_en = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (reg_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                req_done[grant_q] = 1'b1;
                last_d            = grant_q;
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign reg_in    = data_q;
    assign grant_idx = grant_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Handshake invariants: write_en is a single-cycle pulse and at most one client sees done
    a_write_en_single : assert property (@(posedge clk) disable iff (reset)
        reg_write_en |=> !reg_write_en);
    a_done_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_done));

endmodule

// File: doc/std_reg_write_arbiter.md
# std_reg_write_arbiter

Shares one Calyx-style single-cycle register (`in`/`write_en` → `out`/`done`) among `NUM_REQ` clients that each use a go/done handshake. The block sits between the clients and the register's write port. It grants one client at a time, presents that client's latched data to the register, waits for the register's `done`, and returns a one-cycle `done` pulse to the granted client. Arbitration is round-robin or fixed-priority, selected at compile time.

## Interface
- `WIDTH`, 32, data width of the shared register.
- `NUM_REQ`, 4, number of clients (≥2); `IDX_W = $clog2(NUM_REQ)` is derived.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_go` in NUM_REQ: per-client write request; bit i belongs to client i.
- `req_in` in NUM_REQ*WIDTH: per-client data; client i occupies bits [i*WIDTH +: WIDTH].
- `req_done` out NUM_REQ: one-cycle completion pulse to the granted client.
- `reg_in` out WIDTH: data to the register's `in`.
- `reg_write_en` out 1: drives the register's `write_en`.
- `reg_done` in 1: the register's `done`.
- `grant_idx` out IDX_W: index of the current/last granted client.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE. State is registered; outputs are decoded from the state register and datapath registers only.
- **IDLE**
  - If any `req_go` bit is high, pick the winner per the arbitration policy.
  - Latch `grant_idx` ← winner and `data_q` ← `req_in[winner]`.
  - Go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `reg_write_en`=1 and `reg_in`=`data_q`.
  - Go to WAIT unconditionally.
- **WAIT**
  - `reg_write_en`=0.
  - On `reg_done`=1, go to DONE. Otherwise stay, with no timeout.
- **DONE**
  - `req_done[grant_idx]`=1; all other `req_done` bits are 0.
  - Update the round-robin pointer `last_q` ← `grant_idx`.
  - Go to IDLE.
- `reg_in` holds `data_q` in every state; it is only meaningful in ISSUE.
- **Client rules**
  - A client must hold `req_go` until it sees `req_done` and drop it in the following cycle.
  - If a client's `req_go` is still high in IDLE, it is a new request.
  - Dropping `req_go` after the grant does not abort the transaction; the write and the `done` pulse still occur.
  - `req_in` is sampled only in the IDLE cycle that grants; later changes are ignored.
- Requests from non-granted clients are held off with no `req_done`. There is no queueing beyond the `req_go` level.
- **Reset values:** state=IDLE, `data_q`=0, `grant_idx`=0, `last_q`=NUM_REQ-1, `req_done`=0, `reg_write_en`=0, `busy`=0.
- **Reset mid-transaction:** return to IDLE with no `req_done` pulse. If reset is asserted during ISSUE, the register's own reset clears it anyway.

## Timing
- `req_go` is high at cycle 0 with the block in IDLE:
  - `reg_write_en`=1 in cycle 1.
  - The register's `done` is high in cycle 2.
  - `req_done` pulses in cycle 3.
  - The block is back in IDLE in cycle 4.
  - Go-to-done latency is 3 cycles.
- Throughput is one write per 4 cycles. Back-to-back grants to different clients have `reg_write_en` pulses 4 cycles apart.
- If `reg_done` is delayed k extra cycles, latency is 3+k.
- `reg_write_en` is never high for more than one consecutive cycle.
- At most one `req_done` bit is high in any cycle.

## Configuration
- Macro: `STD_REG_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin. The search starts at `(last_q+1) mod NUM_REQ` and wraps to index 0 after NUM_REQ-1. The first winner after reset is the lowest requesting index.
- **Undefined:** fixed priority; the lowest requesting index always wins. `last_q` is still updated but unused for selection.

## Test plan
- **Single request:** with reset released, `req_go`=0b0001 and `req_in[0]`=0xDEADBEEF.
  - Required: `reg_write_en` high only in cycle 1 with `reg_in`=0xDEADBEEF.
  - Required: `req_done`=0b0001 only in cycle 3, with `grant_idx`=0.
- **Round-robin (macro defined):** all four `req_go` held high, each client dropping go after its done.
  - Required grant order is 0, 1, 2, 3.
  - If client 0 re-raises after its done, the order continues 0, 1, 2, 3, 0, i.e. wrap-around.
- **Fixed priority (macro undefined):** `req_go`=0b1010 continuously, with client 1 re-requesting immediately.
  - Required: client 3 is never granted while client 1 keeps requesting.
- **Stalled register:** `reg_done` held low for 5 cycles after ISSUE.
  - Required: the block stays in WAIT, `busy`=1, `req_done` is not asserted.
  - Required: `req_done` pulses the cycle after `reg_done` rises.
- **Data latch:** `req_in[2]` changes from 0x11 to 0x22 in the cycle after the grant.
  - Required: `reg_in`=0x11 during ISSUE.
- **Reset mid-transaction:** reset asserted in WAIT.
  - Required: next cycle state=IDLE, `req_done`=0, `busy`=0, `grant_idx`=0.
  - Required: no `req_done` pulse ever appears for the aborted request.
